ifmap_row_framer: RTL and testbench
===================================

Name: ifmap_row_framer

Overview:
- Upstream feeder for the CNN IFmap buffer port.
- Accepts a raw 16-bit activation stream with per-row end markers from the host/DMA side.
- Produces 18-bit IFmap words: bit17 marks start-of-row, bit16 marks end-of-row, bits15:0 carry data. Writes them through the buffer's write-enable/ready handshake.
- On request, appends a zero "flush row" of filter_size words so the accelerator emits its last psum.

Parameters:
- DATA_WIDTH, 16, activation data width.
- IFMAP_BUFFER_WIDTH, DATA_WIDTH+2, output word width (start flag + end flag + data).
- FILTER_SIZE_WIDTH, 5, width of the filter_size input.
- ROW_CNT_WIDTH, 16, width of the row counter and word-in-row counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  framer accepts input only while 1.
- filter_size  in  FILTER_SIZE_WIDTH  flush-row length; sampled when flush is accepted.
- s_data  in  DATA_WIDTH  input activation.
- s_valid  in  1  s_data is valid.
- s_last  in  1  s_data is the last word of its row.
- s_ready  out  1  framer can accept a word this cycle.
- flush  in  1  single-cycle request to append a flush row.
- flush_busy  out  1  a flush is pending or being emitted.
- IFmap_buffer_in  out  IFMAP_BUFFER_WIDTH  framed word to the IFmap buffer.
- IFmap_buffer_write_enable  out  1  IFmap_buffer_in is valid.
- IFmap_buffer_ready  in  1  buffer accepts the word on this edge.
- rows_done  out  ROW_CNT_WIDTH  count of completed rows written (flush rows included).
- short_row  out  1  sticky: a data row ended with fewer than filter_size words.

Behaviour:
- Reset (async, reset=0): state IDLE, output register empty, write_enable=0, IFmap_buffer_in=0, s_ready=0, flush_busy=0, rows_done=0, short_row=0, word counter=0, sof_pending=1. Reset mid-row discards the partial row; no word is replayed.
- A transfer to the buffer occurs on an edge where write_enable=1 and IFmap_buffer_ready=1. IFmap_buffer_in and write_enable stay stable until that transfer.
- Output stage is one register. s_ready = (state==STREAM) && (!write_enable || IFmap_buffer_ready). An input is accepted on an edge with s_valid && s_ready and appears on IFmap_buffer_in the next cycle (latency 1). Full throughput: one word per cycle.
- Framing:
  - bit17 = sof_pending at accept time; bit16 = s_last.
  - After an accept, sof_pending <= s_last.
  - A one-word row carries both flags (2'b11).
- Counters:
  - Word counter increments per accepted word and clears on s_last.
  - On s_last, if (count+1) < filter_size, set short_row (cleared only by reset).
  - rows_done increments on the edge where an end-flagged word transfers to the buffer, not when it is accepted; wraps at 2^ROW_CNT_WIDTH.
- States:
  - IDLE: go to STREAM when enable=1.
  - STREAM: go to IDLE when enable=0 and the output register is empty. Go to FLUSH when flush_pending=1 and sof_pending=1, i.e. at a row boundary.
  - FLUSH: emit filter_size zero words; the first has bit17=1, the last has bit16=1 (filter_size=1 gives 2'b11). s_ready=0 throughout. After the last flush word transfers, clear flush_pending and return to STREAM.
- flush handling:
  - flush is latched into flush_pending (flush_busy = flush_pending || state==FLUSH).
  - flush raised mid-row is held until the current row's end is accepted.
  - flush while flush_busy=1 is ignored.
  - filter_size latches when the flush enters FLUSH.
  - filter_size=0: flush_pending clears with no words written.
- Simultaneous flush and final s_last in one cycle: the data word is accepted, then FLUSH begins after it.
- IFmap_buffer_ready low: the output holds, s_ready drops, and no words are lost or duplicated.

Decomposition:
- Shared CNN package holds:
  - flag bit positions: SOF_BIT = IFMAP_BUFFER_WIDTH-1, EOF_BIT = IFMAP_BUFFER_WIDTH-2;
  - the state encoding: IDLE, STREAM, FLUSH.
- One natural sub-module, ifmap_out_reg: a single-entry valid/ready output register with hold-on-stall. Use it for both the data path and the flush path.

Test Plan:
- Row of 4 words 0x0001..0x0004, s_last on the 4th, buffer always ready -> outputs 0x20001, 0x00002, 0x00003, 0x10004 on consecutive cycles, each one cycle after accept; rows_done=1.
- Single-word row 0x00AA with s_last -> output 0x300AA; next row's first word has bit17=1.
- IFmap_buffer_ready=0 for 5 cycles mid-row -> output held stable, s_ready=0, no drop or duplicate; the sequence resumes intact.
- filter_size=4, flush pulsed on the 2nd word of a 4-word row -> the row completes, then 0x20000, 0x00000, 0x00000, 0x10000 are written; flush_busy falls after the last; rows_done=2.
- filter_size=4, row of 3 words -> short_row=1 and stays 1 until reset; the flush with filter_size=0 writes nothing.
- Assert reset=0 mid-row after 2 words -> all outputs zero immediately (asynchronous); after release the next word has bit17=1 and rows_done=0.

Source files
------------

// File: rtl/ifmap_row_framer_pkg.sv
// Shared CNN framing definitions: default widths, flag bit positions and the
// framer state encoding.
package ifmap_row_framer_pkg;

    localparam int DEF_DATA_WIDTH         = 16;
    localparam int DEF_IFMAP_BUFFER_WIDTH = DEF_DATA_WIDTH + 2;
    localparam int DEF_FILTER_SIZE_WIDTH  = 5;
    localparam int DEF_ROW_CNT_WIDTH      = 16;

    // Start-of-row flag sits in the MSB, end-of-row flag just below it.
    function automatic int sof_bit(input int buffer_width);
        return buffer_width - 1;
    endfunction

    function automatic int eof_bit(input int buffer_width);
        return buffer_width - 2;
    endfunction

    localparam int SOF_BIT = sof_bit(DEF_IFMAP_BUFFER_WIDTH);
    localparam int EOF_BIT = eof_bit(DEF_IFMAP_BUFFER_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/ifmap_row_framer_out_reg.sv
// Single-entry valid/ready output register. The held word stays stable until
// the downstream side accepts it; a new word may enter on the same edge.
module ifmap_out_reg #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Room for a new word when empty or when the held word leaves this edge.
    assign o_ready = !r_valid || i_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    // Load on free slot, otherwise hold.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the data register is reset too, because the buffer input must read zero in reset.
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/ifmap_row_framer.sv
// Frames a raw activation stream into IFmap words {sof, eof, data} and can
// append a zero flush row of filter_size words at a row boundary.
module ifmap_row_framer
    import ifmap_row_framer_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int IFMAP_BUFFER_WIDTH = DATA_WIDTH + 2,
    parameter int FILTER_SIZE_WIDTH  = DEF_FILTER_SIZE_WIDTH,
    parameter int ROW_CNT_WIDTH      = DEF_ROW_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [FILTER_SIZE_WIDTH-1:0]  filter_size,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    input  logic                          flush,
    output logic                          flush_busy,
    output logic [IFMAP_BUFFER_WIDTH-1:0] IFmap_buffer_in,
    output logic                          IFmap_buffer_write_enable,
    input  logic                          IFmap_buffer_ready,
    output logic [ROW_CNT_WIDTH-1:0]      rows_done,
    output logic                          short_row
);

    localparam int EOF_POS = eof_bit(IFMAP_BUFFER_WIDTH);

    state_t                          r_state;
    logic                            r_sof_pending;
    logic                            r_flush_pending;
    logic                            r_short_row;
    logic [ROW_CNT_WIDTH-1:0]        r_word_cnt;
    logic [ROW_CNT_WIDTH-1:0]        r_rows_done;
    logic [FILTER_SIZE_WIDTH-1:0]    r_flush_len;
    logic [FILTER_SIZE_WIDTH-1:0]    r_flush_idx;

    logic                            w_out_ready;
    logic                            w_xfer;
    logic                            w_go_flush;
    logic                            w_accept;
    logic                            w_flush_load;
    logic                            w_flush_done;
    logic                            w_row_short;
    logic                            w_in_valid;
    logic [IFMAP_BUFFER_WIDTH-1:0]   w_in_data;
    logic [IFMAP_BUFFER_WIDTH-1:0]   w_data_word;
    logic [IFMAP_BUFFER_WIDTH-1:0]   w_flush_word;

    assign w_xfer      = IFmap_buffer_write_enable && IFmap_buffer_ready;
    // Flush starts only at a row boundary; that cycle blocks new input so the
    // flush row cannot interleave with a data row.
    assign w_go_flush  = (r_state == ST_STREAM) && r_flush_pending && r_sof_pending;
    assign s_ready     = (r_state == ST_STREAM) && enable && !w_go_flush && w_out_ready;
    assign w_accept    = s_valid && s_ready;

    assign w_flush_load = (r_state == ST_FLUSH) && (r_flush_idx != r_flush_len) && w_out_ready;
    // All flush words loaded and the last one has left (or none was needed).
    assign w_flush_done = (r_state == ST_FLUSH) && (r_flush_idx == r_flush_len)
                          && (!IFmap_buffer_write_enable || IFmap_buffer_ready);

    assign w_row_short = ({1'b0, r_word_cnt} + {{ROW_CNT_WIDTH{1'b0}}, 1'b1})
                         < {{(ROW_CNT_WIDTH + 1 - FILTER_SIZE_WIDTH){1'b0}}, filter_size};

    assign w_data_word  = {r_sof_pending, s_last, s_data};
    assign w_flush_word = {(r_flush_idx == '0),
                           (r_flush_idx == r_flush_len - {{(FILTER_SIZE_WIDTH-1){1'b0}}, 1'b1}),
                           {DATA_WIDTH{1'b0}}};

    assign w_in_valid = w_accept || w_flush_load;
    assign w_in_data  = (r_state == ST_FLUSH) ? w_flush_word : w_data_word;

    assign flush_busy = r_flush_pending || (r_state == ST_FLUSH);
    assign rows_done  = r_rows_done;
    assign short_row  = r_short_row;

    ifmap_out_reg #(
        .WIDTH (IFMAP_BUFFER_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .i_data  (w_in_data),
        .i_valid (w_in_valid),
        .o_ready (w_out_ready),
        .o_data  (IFmap_buffer_in),
        .o_valid (IFmap_buffer_write_enable),
        .i_ready (IFmap_buffer_ready)
    );

    // Mode FSM: idle / stream data / emit flush row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_flush_len <= '0;
            r_flush_idx <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_go_flush) begin
                        r_state     <= ST_FLUSH;
                        r_flush_len <= filter_size;
                        r_flush_idx <= '0;
                    end else if (!enable && !IFmap_buffer_write_enable) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (w_flush_load) begin
                        r_flush_idx <= r_flush_idx + 1'b1;
                    end
                    if (w_flush_done) begin
                        r_state <= ST_STREAM;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Latch a flush request until its flush row has fully left.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flush_pending <= 1'b0;
        end else if (w_flush_done) begin
            r_flush_pending <= 1'b0;
        end else if (flush && !flush_busy) begin
            r_flush_pending <= 1'b1;
        end
    end

    // Row framing and word-in-row counting on each accepted word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sof_pending <= 1'b1;
            r_word_cnt    <= '0;
            r_short_row   <= 1'b0;
        end else if (w_accept) begin
            r_sof_pending <= s_last;
            if (s_last) begin
                r_word_cnt <= '0;
                if (w_row_short) begin
                    r_short_row <= 1'b1;
                end
            end else begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    // Count rows when their end-flagged word actually reaches the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rows_done <= '0;
        end else if (w_xfer && IFmap_buffer_in[EOF_POS]) begin
            r_rows_done <= r_rows_done + 1'b1;
        end
    end

endmodule

// File: tb/tb_ifmap_row_framer.sv
// Scoreboard bench for ifmap_row_framer: directed rows, stalls, flushes and
// reset; expected words are queued at issue time and popped by a monitor.
module tb_ifmap_row_framer;

    localparam int DW = 16;
    localparam int BW = 18;
    localparam int FW = 5;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [FW-1:0] filter_size;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          flush;
    logic          flush_busy;
    logic [BW-1:0] IFmap_buffer_in;
    logic          IFmap_buffer_write_enable;
    logic          IFmap_buffer_ready;
    logic [RW-1:0] rows_done;
    logic          short_row;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] mon_exp;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    ifmap_row_framer dut (
        .clk                       (clk),
        .reset                     (reset),
        .enable                    (enable),
        .filter_size               (filter_size),
        .s_data                    (s_data),
        .s_valid                   (s_valid),
        .s_last                    (s_last),
        .s_ready                   (s_ready),
        .flush                     (flush),
        .flush_busy                (flush_busy),
        .IFmap_buffer_in           (IFmap_buffer_in),
        .IFmap_buffer_write_enable (IFmap_buffer_write_enable),
        .IFmap_buffer_ready        (IFmap_buffer_ready),
        .rows_done                 (rows_done),
        .short_row                 (short_row)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer to the buffer must match the next queued word.
    always @(negedge clk) begin
        if (reset && IFmap_buffer_write_enable && IFmap_buffer_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none", IFmap_buffer_in);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_word", 32'(IFmap_buffer_in), 32'(mon_exp));
            end
        end
    end

    // Present one word until accepted; optionally queue its expected framing,
    // pulse flush on its first cycle, and check the one-cycle latency.
    task automatic send(input logic [DW-1:0] d, input logic last, input logic [BW-1:0] exp,
                        input bit do_push, input bit pulse_flush, input bit chk_lat);
        bit got;
        got     = 1'b0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        flush   = pulse_flush;
        if (do_push) exp_q.push_back(exp);
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no s_ready expected accept of 0x%0h", d);
        end else if (chk_lat) begin
            check("latency_word", 32'({IFmap_buffer_write_enable, IFmap_buffer_in}),
                  32'({1'b1, exp}));
        end
    endtask

    // Wait (bounded) until all queued words are written and no flush is busy.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || flush_busy || IFmap_buffer_write_enable) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_drain_in_time"}, 32'(n < 300), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset              = 1'b0;
        enable             = 1'b0;
        filter_size        = 5'd1;
        s_data             = '0;
        s_valid            = 1'b0;
        s_last             = 1'b0;
        flush              = 1'b0;
        IFmap_buffer_ready = 1'b1;

        // Reset state
        #12;
        check("rst_buffer_in", 32'(IFmap_buffer_in), 32'h0);
        check("rst_write_enable", 32'(IFmap_buffer_write_enable), 32'h0);
        check("rst_s_ready", 32'(s_ready), 32'h0);
        check("rst_flush_busy", 32'(flush_busy), 32'h0);
        check("rst_rows_done", 32'(rows_done), 32'h0);
        check("rst_short_row", 32'(short_row), 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b1;

        // Four-word row at full throughput
        send(16'h0001, 1'b0, 18'h20001, 1'b1, 1'b0, 1'b1);
        send(16'h0002, 1'b0, 18'h00002, 1'b1, 1'b0, 1'b1);
        send(16'h0003, 1'b0, 18'h00003, 1'b1, 1'b0, 1'b1);
        send(16'h0004, 1'b1, 18'h10004, 1'b1, 1'b0, 1'b1);
        drain("row4");
        check("row4_rows_done", 32'(rows_done), 32'd1);

        // Single-word row, then a two-word row whose first word gets sof
        send(16'h00AA, 1'b1, 18'h300AA, 1'b1, 1'b0, 1'b0);
        send(16'h00BB, 1'b0, 18'h200BB, 1'b1, 1'b0, 1'b0);
        send(16'h00CC, 1'b1, 18'h100CC, 1'b1, 1'b0, 1'b0);
        drain("single");
        check("single_rows_done", 32'(rows_done), 32'd3);
        check("single_short_row", 32'(short_row), 32'd0);

        // Buffer stall for 5 cycles mid-row
        send(16'h0011, 1'b0, 18'h20011, 1'b1, 1'b0, 1'b0);
        send(16'h0012, 1'b0, 18'h00012, 1'b1, 1'b0, 1'b0);
        IFmap_buffer_ready = 1'b0;
        s_data  = 16'h0013;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold_word", 32'(IFmap_buffer_in), 32'h00012);
            check("stall_hold_we", 32'(IFmap_buffer_write_enable), 32'd1);
            check("stall_s_ready", 32'(s_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        IFmap_buffer_ready = 1'b1;
        send(16'h0013, 1'b0, 18'h00013, 1'b1, 1'b0, 1'b0);
        send(16'h0014, 1'b1, 18'h10014, 1'b1, 1'b0, 1'b0);
        drain("stall");
        check("stall_rows_done", 32'(rows_done), 32'd4);

        // Flush requested mid-row with filter_size = 4
        filter_size = 5'd4;
        send(16'h0021, 1'b0, 18'h20021, 1'b1, 1'b0, 1'b0);
        send(16'h0022, 1'b0, 18'h00022, 1'b1, 1'b1, 1'b0);
        check("flush_busy_raised", 32'(flush_busy), 32'd1);
        send(16'h0023, 1'b0, 18'h00023, 1'b1, 1'b0, 1'b0);
        send(16'h0024, 1'b1, 18'h10024, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(18'h20000);
        exp_q.push_back(18'h00000);
        exp_q.push_back(18'h00000);
        exp_q.push_back(18'h10000);
        drain("flush4");
        check("flush4_busy_low", 32'(flush_busy), 32'd0);
        check("flush4_rows_done", 32'(rows_done), 32'd6);

        // Short row with filter_size = 4, then an empty flush
        send(16'h0031, 1'b0, 18'h20031, 1'b1, 1'b0, 1'b0);
        send(16'h0032, 1'b0, 18'h00032, 1'b1, 1'b0, 1'b0);
        send(16'h0033, 1'b1, 18'h10033, 1'b1, 1'b0, 1'b0);
        drain("short");
        check("short_row_set", 32'(short_row), 32'd1);
        filter_size = 5'd0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush0_busy", 32'(flush_busy), 32'd1);
        drain("flush0");
        check("flush0_rows_done", 32'(rows_done), 32'd7);
        check("short_row_sticky", 32'(short_row), 32'd1);

        // Asynchronous reset mid-row after two accepted words
        send(16'h0041, 1'b0, 18'h20041, 1'b1, 1'b0, 1'b0);
        send(16'h0042, 1'b0, 18'h00042, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check("arst_buffer_in", 32'(IFmap_buffer_in), 32'h0);
        check("arst_write_enable", 32'(IFmap_buffer_write_enable), 32'h0);
        check("arst_s_ready", 32'(s_ready), 32'h0);
        check("arst_rows_done", 32'(rows_done), 32'h0);
        check("arst_short_row", 32'(short_row), 32'h0);
        check("arst_flush_busy", 32'(flush_busy), 32'h0);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        filter_size = 5'd1;
        send(16'h0051, 1'b1, 18'h30051, 1'b1, 1'b0, 1'b0);
        drain("post_rst");
        check("post_rst_rows_done", 32'(rows_done), 32'd1);
        check("post_rst_short_row", 32'(short_row), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
